bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for the 32-bit internal bus mux. Up to 24 sources
//  (R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C) request the bus; one owner is granted at a time.
//  Output select drives the mux select directly (code = source index; 31 = no driver, mux outputs 0).
//  Control unit can force a select code, overriding arbitration.
// PARAMETERS
//  NUM_SRC   24  number of requesters; indices 0..NUM_SRC-1 equal mux select codes
//  SEL_W     5   select width
//  MAX_HOLD  4   max consecutive cycles an owner keeps the bus while another request is pending
// PORTS
//  clock      in   1        system clock, rising edge
//  clear      in   1        asynchronous, active-low reset
//  req        in   NUM_SRC  level request per source; bit i = mux code i
//  force_en   in   1        control-unit override enable
//  force_sel  in   SEL_W    override select code
//  grant      out  NUM_SRC  one-hot grant, registered (all 0 when idle/forced)
//  select     out  SEL_W    registered bus mux select
//  bus_valid  out  1        1 when select names a driving source
// BEHAVIOUR
//  - Reset (clear=0, async, any time incl. mid-grant): grant=0, select=31, bus_valid=0,
//    state=IDLE, hold_cnt=0, last=NUM_SRC-1 (so source 0 wins first). Outputs change without clock edge.
//  - All outputs registered; decision made from inputs at edge t, visible after edge t. Latency 1 cycle.
//  - RR search: first set req bit starting at last+1, wrapping NUM_SRC-1 -> 0. last updates on each new grant.
//  - States: IDLE, GRANT, FORCE. force_en has priority over everything in every state.
//  - IDLE: force_en -> FORCE. Else any req -> GRANT to RR winner, hold_cnt=1. Else stay, select=31.
//  - GRANT (owner o):
//    * req[o]=0 -> another req pending: grant next RR winner (hold_cnt=1); none: IDLE, select=31.
//    * req[o]=1, hold_cnt<MAX_HOLD -> keep o, hold_cnt+1.
//    * req[o]=1, hold_cnt>=MAX_HOLD, other req pending -> preempt to next RR winner, hold_cnt=1.
//    * req[o]=1, no other req -> keep o; hold_cnt saturates at MAX_HOLD.
//  - FORCE: grant=0, select=force_sel, bus_valid=1; last and hold_cnt unchanged.
//    force_sel>=NUM_SRC -> select=31, bus_valid=0. force_en=0 -> arbitrate as IDLE that edge.
//  - grant one-hot or zero at all times; select==index of set grant bit when grant!=0.
//  - req bits dropping/rising same edge as decision: only sampled values used; no glitch path.
// TESTING
//  1 reset: clear=0 with req=all 1s -> grant=0, select=31, bus_valid=0 immediately; first edge after
//    release with req[0] set -> grant[0], select=0.
//  2 lone hold: req[20] (PC) high 10 cycles, others 0 -> select=20 from cycle 1 through 10, no
//    preemption; req[20] low -> next cycle select=31, bus_valid=0.
//  3 fairness: from reset req[3]&req[21] held -> select 3 x4 cycles, 21 x4, 3 x4 (MAX_HOLD=4).
//  4 wrap: owner 23 (C) drops, req[0]&req[22] set -> next grant 0 (search wraps 23 -> 0).
//  5 force: owner 5, force_en=1 force_sel=19 -> next cycle select=19, grant=0; force_en=0 with
//    req[5]&req[6] -> grant 6 (last still 5); force_sel=27 -> select=31, bus_valid=0.
//  6 async reset mid-grant: owner 12, hold_cnt=2, clear pulsed low between edges -> outputs
//    reset before next edge; then arbitration restarts from source 0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with control-unit force override.
// Registered one-hot grant and mux select for the internal bus.
module bus_arbiter #(
  parameter int NUM_SRC  = 24,
  parameter int SEL_W    = 5,
  parameter int MAX_HOLD = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic [NUM_SRC-1:0] req,
  input  logic               force_en,
  input  logic [SEL_W-1:0]   force_sel,
  output logic [NUM_SRC-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               bus_valid
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [SEL_W-1:0] NO_SEL = '1;
  localparam logic [SEL_W-1:0] NSRC = SEL_W'(NUM_SRC);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    FORCE
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   hold_q, hold_d;

  logic               rr_found;
  logic [SEL_W-1:0]   rr_idx;
  logic               own_req;
  logic               other_pend;
  logic               do_new;
  logic               go_idle;

  // First requester after the last owner, wrapping to 0.
  always_comb begin
    int p;
    p        = 0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      p = (int'(last_q) + k) % NUM_SRC;
      if (!rr_found && req[p]) begin
        rr_found = 1'b1;
        rr_idx   = SEL_W'(p);
      end
    end
  end

  assign own_req    = |(req & grant_q);
  assign other_pend = |(req & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    hold_d  = hold_q;
    do_new  = 1'b0;
    go_idle = 1'b0;

    if (force_en) begin
      state_d = FORCE;
      grant_d = '0;
      if (force_sel < NSRC) begin
        sel_d   = force_sel;
        valid_d = 1'b1;
      end else begin
        sel_d   = NO_SEL;
        valid_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        GRANT: begin
          if (!own_req) begin
            do_new  = rr_found;
            go_idle = !rr_found;
          end else if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
          end else if (other_pend) begin
            do_new = 1'b1;
          end
        end
        IDLE, FORCE: begin
          do_new  = rr_found;
          go_idle = !rr_found;
        end
        default: go_idle = 1'b1;
      endcase
    end

    if (do_new) begin
      state_d         = GRANT;
      grant_d         = '0;
      grant_d[rr_idx] = 1'b1;
      sel_d           = rr_idx;
      valid_d         = 1'b1;
      last_d          = rr_idx;
      hold_d          = HOLD_ONE;
    end
    if (go_idle) begin
      state_d = IDLE;
      grant_d = '0;
      sel_d   = NO_SEL;
      valid_d = 1'b0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= NO_SEL;
      valid_q <= 1'b0;
      last_q  <= LAST_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign select    = sel_q;
  assign bus_valid = valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed-vector bench for bus_arbiter.
// Expected values are hand-derived per scenario.
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [23:0] req = '0;
  logic        force_en = 1'b0;
  logic [4:0]  force_sel = '0;
  logic [23:0] grant;
  logic [4:0]  select;
  logic        bus_valid;

  int nvec = 0;
  int nerr = 0;

  bus_arbiter dut (
    .clock     (clock),
    .clear     (clear),
    .req       (req),
    .force_en  (force_en),
    .force_sel (force_sel),
    .grant     (grant),
    .select    (select),
    .bus_valid (bus_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] oh(input int n);
    logic [23:0] v;
    v = '0;
    if (n < 24) v[n] = 1'b1;
    return v;
  endfunction

  // Arbitrated owner s (31 = idle).
  task automatic exp_own(input string tag, input int s);
    chk({tag, ".sel"}, 32'(select), 32'(s));
    chk({tag, ".gnt"}, 32'(grant), 32'(oh(s)));
    chk({tag, ".vld"}, 32'(bus_valid), 32'(s != 31));
  endtask

  task automatic exp_frc(input string tag, input int s);
    chk({tag, ".sel"}, 32'(select), 32'(s));
    chk({tag, ".gnt"}, 32'(grant), 32'd0);
    chk({tag, ".vld"}, 32'(bus_valid), 32'(s != 31));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    req = '0;
    force_en = 1'b0;
    tick();
    clear = 1'b1;
  endtask

  initial begin
    // 1: async reset while all request, then source 0 first
    req = '1;
    tick();
    tick();
    #2;
    clear = 1'b0;
    #1;
    exp_own("rst_async", 31);
    tick();
    exp_own("rst_hold", 31);
    req = 24'h1;
    clear = 1'b1;
    tick();
    exp_own("rst_first", 0);

    // 2: lone holder never preempted
    do_reset();
    req = oh(20);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("lone.sel", 32'(select), 32'd20);
    end
    exp_own("lone_end", 20);
    req = '0;
    tick();
    exp_own("lone_drop", 31);

    // 3: fairness with MAX_HOLD = 4
    do_reset();
    req = oh(3) | oh(21);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("fair.sel", 32'(select), ((i / 4) % 2 == 1) ? 32'd21 : 32'd3);
    end

    // 4: search wraps 23 -> 0
    do_reset();
    req = oh(23);
    tick();
    exp_own("wrap_own", 23);
    req = oh(0) | oh(22);
    tick();
    exp_own("wrap_next", 0);

    // 5: force override
    do_reset();
    req = oh(5);
    tick();
    exp_own("frc_own", 5);
    force_en = 1'b1;
    force_sel = 5'd19;
    tick();
    exp_frc("frc_19", 19);
    force_en = 1'b0;
    req = oh(5) | oh(6);
    tick();
    exp_own("frc_rel", 6);
    force_en = 1'b1;
    force_sel = 5'd27;
    tick();
    exp_frc("frc_27", 31);
    force_en = 1'b0;

    // 6: async reset mid-grant
    do_reset();
    req = oh(12);
    tick();
    exp_own("mid_own", 12);
    tick();
    exp_own("mid_h2", 12);
    #2;
    clear = 1'b0;
    #1;
    exp_own("mid_rst", 31);
    #1;
    clear = 1'b1;
    req = oh(0) | oh(12);
    tick();
    exp_own("mid_restart", 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
